// File: rtl/hazard_scoreboard_pkg.sv
// Shared core constants and types for the decode-stage hazard scoreboard.
//   SB_WIDTH                 : width of one pending vector (one bit per architectural register)
//   REG_IDX_W                : register index width
//   X0_IDX                   : hard-wired integer zero register, never tracked
//   MAX_OUTSTANDING_DEFAULT  : default limit on in-flight long-latency ops
//   CNT_W                    : width of the in-flight counter
package hazard_scoreboard_pkg;

  localparam int SB_WIDTH                = 32;
  localparam int REG_IDX_W               = 5;
  localparam int X0_IDX                  = 0;
  localparam int MAX_OUTSTANDING_DEFAULT = 4;
  localparam int CNT_W                   = 3;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [SB_WIDTH-1:0]  sb_vec_t;
  typedef logic [CNT_W-1:0]     cnt_t;

endpackage

// File: rtl/sb_bank.sv
// One 32-entry pending-register vector.
//   clk, rst : clock and synchronous active-high reset
//   set_en   / set_idx : mark a register pending next cycle
//   clr_en   / clr_idx : clear a register next cycle (set wins on the same index)
//   lk_idx   / lk_hit  : N_LOOKUP read ports; a bit being cleared this cycle reads
//                        as not pending because the register file writes through
//   clr_hit  : raw stored state of the bit addressed by clr_idx
//   pending  : the stored vector
module sb_bank
  import hazard_scoreboard_pkg::*;
#(
  parameter int N_LOOKUP = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set_en,
  input  reg_idx_t                  set_idx,
  input  logic                      clr_en,
  input  reg_idx_t                  clr_idx,
  input  reg_idx_t [N_LOOKUP-1:0]   lk_idx,
  output logic     [N_LOOKUP-1:0]   lk_hit,
  output logic                      clr_hit,
  output sb_vec_t                   pending
);

  sb_vec_t clr_mask;
  sb_vec_t pending_eff;
  sb_vec_t pending_nxt;

  // NOTE: every always_comb output gets a default before any conditional
  // update, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    clr_mask = '0;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
    pending_eff = pending & ~clr_mask;
    pending_nxt = pending_eff;
    // Set is applied after clear so a re-issue to the retiring register wins.
    if (set_en) pending_nxt[set_idx] = 1'b1;
  end

  always_comb begin
    lk_hit = '0;
    for (int i = 0; i < N_LOOKUP; i++) lk_hit[i] = pending_eff[lk_idx[i]];
  end

  assign clr_hit = pending[clr_idx];

  // NOTE: sequential state uses non-blocking assignments only. The vector is
  // ordinary flops rather than a RAM, so reset can clear it in a single cycle.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard for long-latency (multicycle unit) ops.
// Tracks pending integer and FP destinations and raises a decode stall for
// RAW, WAW, load-use and in-flight capacity hazards.
//   clk, rst                     : clock, synchronous active-high reset
//   issue_D                      : decode instruction valid
//   Rs1_D/Rs2_D (+ _use)         : integer sources
//   FP_RS1_D..FP_RS3_D (+ use)   : FP sources
//   RD_D/RegWrite_D, FP_RD_D/FPRegWrite_D : destinations
//   Long_D                       : op completes in the multicycle unit
//   MemRead_E/RD_E, FPMemRead_E/FP_RD_E   : loads in Execute
//   LongWB_valid/_fp/_rd         : long-op writeback
//   StallF, StallD, FlushE       : combinational pipeline controls
//   int_pending, fp_pending      : scoreboard vectors
//   outstanding                  : in-flight long-op count
//   err                          : sticky writeback protocol error
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_D,
  input  logic [4:0]           Rs1_D,
  input  logic [4:0]           Rs2_D,
  input  logic                 Rs1_use_D,
  input  logic                 Rs2_use_D,
  input  logic [4:0]           FP_RS1_D,
  input  logic [4:0]           FP_RS2_D,
  input  logic [4:0]           FP_RS3_D,
  input  logic                 FP_use1_D,
  input  logic                 FP_use2_D,
  input  logic                 FP_use3_D,
  input  logic [4:0]           RD_D,
  input  logic                 RegWrite_D,
  input  logic [4:0]           FP_RD_D,
  input  logic                 FPRegWrite_D,
  input  logic                 Long_D,
  input  logic                 MemRead_E,
  input  logic [4:0]           RD_E,
  input  logic                 FPMemRead_E,
  input  logic [4:0]           FP_RD_E,
  input  logic                 LongWB_valid,
  input  logic                 LongWB_fp,
  input  logic [4:0]           LongWB_rd,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushE,
  output logic [SB_WIDTH-1:0]  int_pending,
  output logic [SB_WIDTH-1:0]  fp_pending,
  output logic [2:0]           outstanding,
  output logic                 err
);

  localparam reg_idx_t X0      = reg_idx_t'(X0_IDX);
  localparam cnt_t     CNT_MAX = cnt_t'(MAX_OUTSTANDING);

  // Lookup port order: int {rd, rs2, rs1}, fp {rd, rs3, rs2, rs1}.
  logic [2:0] int_hit;
  logic [3:0] fp_hit;
  logic       int_clr_hit, fp_clr_hit;

  logic wb_ok, wb_err, int_clr_en, fp_clr_en;
  logic raw, waw, load_use, capacity, hazard;
  logic accept, long_issue, int_set_en, fp_set_en;
  logic cnt_inc, cnt_dec;

  // A writeback is honoured only if it retires a bit that is really pending
  // and something is in flight; otherwise it is flagged and has no effect.
  assign wb_ok      = LongWB_valid & (LongWB_fp ? fp_clr_hit : int_clr_hit)
                      & (outstanding != '0);
  assign wb_err     = LongWB_valid & ~wb_ok;
  assign int_clr_en = wb_ok & ~LongWB_fp;
  assign fp_clr_en  = wb_ok &  LongWB_fp;

  assign raw = (Rs1_use_D & (Rs1_D != X0) & int_hit[0])
             | (Rs2_use_D & (Rs2_D != X0) & int_hit[1])
             | (FP_use1_D & fp_hit[0])
             | (FP_use2_D & fp_hit[1])
             | (FP_use3_D & fp_hit[2]);

  assign waw = (RegWrite_D & int_hit[2]) | (FPRegWrite_D & fp_hit[3]);

  assign load_use = (MemRead_E & (RD_E != X0)
                      & ((Rs1_use_D & (Rs1_D == RD_E)) | (Rs2_use_D & (Rs2_D == RD_E))))
                  | (FPMemRead_E
                      & ((FP_use1_D & (FP_RS1_D == FP_RD_E))
                       | (FP_use2_D & (FP_RS2_D == FP_RD_E))
                       | (FP_use3_D & (FP_RS3_D == FP_RD_E))));

  // A writeback in the same cycle frees a slot, so it lifts the capacity stall.
  assign capacity = Long_D & (outstanding == CNT_MAX) & ~LongWB_valid;

  assign hazard = raw | waw | load_use | capacity;
  assign StallD = issue_D & ~rst & hazard;
  assign StallF = StallD;
  assign FlushE = StallD;

  assign accept     = issue_D & ~StallD;
  assign long_issue = accept & Long_D & (RegWrite_D | FPRegWrite_D);
  assign int_set_en = long_issue & RegWrite_D & (RD_D != X0);
  assign fp_set_en  = long_issue & FPRegWrite_D;

  // Issue and retire in the same cycle cancel; the counter saturates.
  assign cnt_inc = long_issue & ~wb_ok & (outstanding != '1);
  assign cnt_dec = wb_ok & ~long_issue;

  sb_bank #(.N_LOOKUP(3)) u_int_bank (
    .clk     (clk),
    .rst     (rst),
    .set_en  (int_set_en),
    .set_idx (RD_D),
    .clr_en  (int_clr_en),
    .clr_idx (LongWB_rd),
    .lk_idx  ({RD_D, Rs2_D, Rs1_D}),
    .lk_hit  (int_hit),
    .clr_hit (int_clr_hit),
    .pending (int_pending)
  );

  sb_bank #(.N_LOOKUP(4)) u_fp_bank (
    .clk     (clk),
    .rst     (rst),
    .set_en  (fp_set_en),
    .set_idx (FP_RD_D),
    .clr_en  (fp_clr_en),
    .clr_idx (LongWB_rd),
    .lk_idx  ({FP_RD_D, FP_RS3_D, FP_RS2_D, FP_RS1_D}),
    .lk_hit  (fp_hit),
    .clr_hit (fp_clr_hit),
    .pending (fp_pending)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      if (cnt_inc)      outstanding <= outstanding + 3'd1;
      else if (cnt_dec) outstanding <= outstanding - 3'd1;
      if (wb_err) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_D;
  logic [4:0]  Rs1_D, Rs2_D;
  logic        Rs1_use_D, Rs2_use_D;
  logic [4:0]  FP_RS1_D, FP_RS2_D, FP_RS3_D;
  logic        FP_use1_D, FP_use2_D, FP_use3_D;
  logic [4:0]  RD_D, FP_RD_D;
  logic        RegWrite_D, FPRegWrite_D, Long_D;
  logic        MemRead_E, FPMemRead_E;
  logic [4:0]  RD_E, FP_RD_E;
  logic        LongWB_valid, LongWB_fp;
  logic [4:0]  LongWB_rd;
  logic        StallF, StallD, FlushE;
  logic [31:0] int_pending, fp_pending;
  logic [2:0]  outstanding;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst(rst), .issue_D(issue_D),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_use_D(Rs1_use_D), .Rs2_use_D(Rs2_use_D),
    .FP_RS1_D(FP_RS1_D), .FP_RS2_D(FP_RS2_D), .FP_RS3_D(FP_RS3_D),
    .FP_use1_D(FP_use1_D), .FP_use2_D(FP_use2_D), .FP_use3_D(FP_use3_D),
    .RD_D(RD_D), .RegWrite_D(RegWrite_D), .FP_RD_D(FP_RD_D), .FPRegWrite_D(FPRegWrite_D),
    .Long_D(Long_D), .MemRead_E(MemRead_E), .RD_E(RD_E),
    .FPMemRead_E(FPMemRead_E), .FP_RD_E(FP_RD_E),
    .LongWB_valid(LongWB_valid), .LongWB_fp(LongWB_fp), .LongWB_rd(LongWB_rd),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .int_pending(int_pending), .fp_pending(fp_pending),
    .outstanding(outstanding), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    rst = 0; issue_D = 0;
    Rs1_D = 0; Rs2_D = 0; Rs1_use_D = 0; Rs2_use_D = 0;
    FP_RS1_D = 0; FP_RS2_D = 0; FP_RS3_D = 0;
    FP_use1_D = 0; FP_use2_D = 0; FP_use3_D = 0;
    RD_D = 0; RegWrite_D = 0; FP_RD_D = 0; FPRegWrite_D = 0; Long_D = 0;
    MemRead_E = 0; RD_E = 0; FPMemRead_E = 0; FP_RD_E = 0;
    LongWB_valid = 0; LongWB_fp = 0; LongWB_rd = 0;
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic long_int(input logic [4:0] rd);
    issue_D = 1; Long_D = 1; RegWrite_D = 1; RD_D = rd;
  endtask

  task automatic wb(input logic fp, input logic [4:0] rd);
    LongWB_valid = 1; LongWB_fp = fp; LongWB_rd = rd;
  endtask

  function automatic logic [31:0] pack(input bit a[32]);
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = a[i];
    return v;
  endfunction

  // Reference model state: one flag per register plus plain counters.
  bit mi[32], mf[32], ei[32], ef[32];
  int mcnt;
  bit merr;
  bit wb_ok, raw, waw, lu, cap, e_stall, li;
  int pend_q[$];
  int k;

  initial begin
    clear_inputs();

    // Reset with hazards presented: no stall, and a writeback is ignored.
    rst = 1; issue_D = 1; MemRead_E = 1; RD_E = 7; Rs1_D = 7; Rs1_use_D = 1;
    wb(0, 9);
    #1 check("rst_stall_d", 32'(StallD), 0);
    check("rst_stall_f", 32'(StallF), 0);
    check("rst_flush_e", 32'(FlushE), 0);
    tick(); tick();
    clear_inputs();
    check("rst_int_pending", int_pending, 0);
    check("rst_fp_pending", fp_pending, 0);
    check("rst_outstanding", 32'(outstanding), 0);
    check("rst_err", 32'(err), 0);

    // DIV x5, then ADD reading x5 stalls until the x5 writeback.
    long_int(5);
    #1 check("div_issue_stall", 32'(StallD), 0);
    tick(); clear_inputs();
    check("div_pending5", 32'(int_pending[5]), 1);
    check("div_outstanding", 32'(outstanding), 1);
    issue_D = 1; Rs1_D = 5; Rs1_use_D = 1; RegWrite_D = 1; RD_D = 6;
    #1 check("add_raw_stall", 32'(StallD), 1);
    tick();
    check("add_raw_stall_hold", 32'(StallD), 1);
    wb(0, 5);
    #1 check("add_wb_writethrough", 32'(StallD), 0);
    tick(); clear_inputs();
    check("div_pending5_clr", 32'(int_pending[5]), 0);
    check("div_outstanding_clr", 32'(outstanding), 0);

    // Load-use on x7; RD_E = x0 never stalls.
    issue_D = 1; MemRead_E = 1; RD_E = 7; Rs2_D = 7; Rs2_use_D = 1;
    #1 check("lu_stall_d", 32'(StallD), 1);
    check("lu_stall_f", 32'(StallF), 1);
    check("lu_flush_e", 32'(FlushE), 1);
    RD_E = 0; Rs2_D = 0;
    #1 check("lu_x0_no_stall", 32'(StallD), 0);
    tick(); clear_inputs();

    // Fill capacity with x1..x4, then a fifth long op.
    for (int r = 1; r <= 4; r++) begin
      long_int(5'(r));
      #1 check("fill_no_stall", 32'(StallD), 0);
      tick(); clear_inputs();
    end
    check("fill_outstanding", 32'(outstanding), 4);
    long_int(6);
    #1 check("cap_stall", 32'(StallD), 1);
    wb(0, 1);
    #1 check("cap_wb_no_stall", 32'(StallD), 0);
    tick(); clear_inputs();
    check("cap_outstanding", 32'(outstanding), 4);
    check("cap_int_pending", int_pending, 32'h0000_005C);

    // Re-issue to x3 while x3 retires: set wins.
    long_int(3); wb(0, 3);
    #1 check("setclr_no_stall", 32'(StallD), 0);
    tick(); clear_inputs();
    check("setclr_pending3", 32'(int_pending[3]), 1);
    check("setclr_outstanding", 32'(outstanding), 4);
    foreach (pend_q[i]) pend_q.delete(i);
    for (int r = 2; r <= 6; r++) begin
      if (r == 5) continue;
      wb(0, 5'(r)); tick(); clear_inputs();
    end
    check("drain_outstanding", 32'(outstanding), 0);
    check("drain_int_pending", int_pending, 0);
    check("drain_err", 32'(err), 0);

    // FDIV f0 pending; FMADD reading f0 as rs3.
    issue_D = 1; Long_D = 1; FPRegWrite_D = 1; FP_RD_D = 0;
    tick(); clear_inputs();
    check("fdiv_f0_pending", fp_pending, 32'h1);
    issue_D = 1; FPRegWrite_D = 1; FP_RD_D = 10; FP_RS1_D = 1; FP_RS2_D = 2; FP_RS3_D = 0;
    FP_use1_D = 1; FP_use2_D = 1; FP_use3_D = 1;
    #1 check("fmadd_rs3_stall", 32'(StallD), 1);
    FP_use3_D = 0;
    #1 check("fmadd_rs3_unused", 32'(StallD), 0);
    tick(); clear_inputs();
    wb(1, 0); tick(); clear_inputs();
    check("f0_retired", fp_pending, 0);
    check("f0_err", 32'(err), 0);

    // Stray writeback sets sticky err; reset clears everything.
    wb(0, 9); tick(); clear_inputs();
    check("stray_err", 32'(err), 1);
    tick();
    check("stray_err_sticky", 32'(err), 1);
    rst = 1; tick(); clear_inputs();
    check("rst2_err", 32'(err), 0);
    check("rst2_int", int_pending, 0);
    check("rst2_fp", fp_pending, 0);
    check("rst2_outstanding", 32'(outstanding), 0);

    // Randomized run against the behavioural model.
    for (int r = 0; r < 32; r++) begin mi[r] = 0; mf[r] = 0; end
    mcnt = 0; merr = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      pend_q.delete();
      for (int r = 0; r < 32; r++) begin
        if (mi[r]) pend_q.push_back(r);
        if (mf[r]) pend_q.push_back(32 + r);
      end
      rst          = ($urandom_range(0, 99) < 2);
      issue_D      = ($urandom_range(0, 3) != 0);
      Rs1_D        = 5'($urandom_range(0, 7));
      Rs2_D        = 5'($urandom_range(0, 7));
      Rs1_use_D    = 1'($urandom);
      Rs2_use_D    = 1'($urandom);
      FP_RS1_D     = 5'($urandom_range(0, 7));
      FP_RS2_D     = 5'($urandom_range(0, 7));
      FP_RS3_D     = 5'($urandom_range(0, 7));
      FP_use1_D    = 1'($urandom);
      FP_use2_D    = 1'($urandom);
      FP_use3_D    = ($urandom_range(0, 3) == 0);
      RD_D         = 5'($urandom_range(0, 7));
      FP_RD_D      = 5'($urandom_range(0, 7));
      RegWrite_D   = ($urandom_range(0, 1) == 0);
      FPRegWrite_D = ($urandom_range(0, 9) < 3);
      Long_D       = ($urandom_range(0, 9) < 3);
      MemRead_E    = ($urandom_range(0, 3) == 0);
      RD_E         = 5'($urandom_range(0, 7));
      FPMemRead_E  = ($urandom_range(0, 6) == 0);
      FP_RD_E      = 5'($urandom_range(0, 7));
      if (pend_q.size() > 0 && $urandom_range(0, 99) < 40) begin
        k = pend_q[$urandom_range(0, pend_q.size() - 1)];
        wb(k >= 32, 5'(k % 32));
      end else if ($urandom_range(0, 99) < 3) begin
        wb(1'($urandom), 5'($urandom_range(0, 7)));
      end else begin
        LongWB_valid = 0; LongWB_fp = 0; LongWB_rd = 0;
      end
      #1;

      // Expected hazards from the current model state.
      wb_ok = LongWB_valid && mcnt > 0 && (LongWB_fp ? mf[LongWB_rd] : mi[LongWB_rd]);
      ei = mi; ef = mf;
      if (wb_ok) begin
        if (LongWB_fp) ef[LongWB_rd] = 0;
        else           ei[LongWB_rd] = 0;
      end
      raw = (Rs1_use_D && Rs1_D != 0 && ei[Rs1_D]) || (Rs2_use_D && Rs2_D != 0 && ei[Rs2_D])
         || (FP_use1_D && ef[FP_RS1_D]) || (FP_use2_D && ef[FP_RS2_D]) || (FP_use3_D && ef[FP_RS3_D]);
      waw = (RegWrite_D && ei[RD_D]) || (FPRegWrite_D && ef[FP_RD_D]);
      lu  = (MemRead_E && RD_E != 0 && ((Rs1_use_D && Rs1_D == RD_E) || (Rs2_use_D && Rs2_D == RD_E)))
         || (FPMemRead_E && ((FP_use1_D && FP_RS1_D == FP_RD_E) || (FP_use2_D && FP_RS2_D == FP_RD_E)
                          || (FP_use3_D && FP_RS3_D == FP_RD_E)));
      cap = Long_D && mcnt == MAX && !LongWB_valid;
      e_stall = !rst && issue_D && (raw || waw || lu || cap);

      check("rnd_stall_d", 32'(StallD), 32'(e_stall));
      check("rnd_stall_f", 32'(StallF), 32'(e_stall));
      check("rnd_flush_e", 32'(FlushE), 32'(e_stall));
      check("rnd_int_pending", int_pending, pack(mi));
      check("rnd_fp_pending", fp_pending, pack(mf));
      check("rnd_outstanding", 32'(outstanding), 32'(mcnt));
      check("rnd_err", 32'(err), 32'(merr));

      // Model update for the coming edge.
      if (rst) begin
        for (int r = 0; r < 32; r++) begin mi[r] = 0; mf[r] = 0; end
        mcnt = 0; merr = 0;
      end else begin
        if (LongWB_valid && !wb_ok) merr = 1;
        li = issue_D && !e_stall && Long_D && (RegWrite_D || FPRegWrite_D);
        if (wb_ok) begin
          if (LongWB_fp) mf[LongWB_rd] = 0;
          else           mi[LongWB_rd] = 0;
        end
        if (li && RegWrite_D && RD_D != 0) mi[RD_D] = 1;
        if (li && FPRegWrite_D)            mf[FP_RD_D] = 1;
        if (li && !wb_ok && mcnt < 7)      mcnt++;
        else if (wb_ok && !li)             mcnt--;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
